// File: rtl/uart_pkg.sv
// Shared definitions for the UART-side blocks: default byte width,
// arbiter state encoding and a constant-friendly ceil(log2) helper.
package uart_pkg;

  localparam int DATA_SIZE_DEF = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_e;

  // ceil(log2(value)); returns 0 for value <= 1
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: scans from last_grant+1 upward
// (wrapping) and returns the first asserted request as a one-hot pick.
module rr_pick
  import uart_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_grant_i,
  output logic [N-1:0]  pick_o,
  output logic          any_o
);

  logic          found;
  logic [IW-1:0] idx;

  // First valid index after the previous owner wins
  always_comb begin
    pick_o = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last_grant_i) + k) % N);
      if (!found && req_i[idx]) begin
        pick_o[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter in front of the single UART TX path.
// The owner keeps the grant until its last byte is accepted or until the
// stall watchdog reclaims it after STALL_TIMEOUT cycles without data.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ       = 4,
  parameter  int DATA_SIZE     = DATA_SIZE_DEF,
  parameter  int STALL_TIMEOUT = 1024,
  parameter  int CNT_W         = 16,
  localparam int ID_W          = clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         wait_request_write,
  output logic                         trans,
  output logic [DATA_SIZE-1:0]         bus_data_in,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         busy,
  output logic                         pkt_done,
  output logic                         stall_err,
  output logic [ID_W-1:0]              stall_id,
  output logic [CNT_W-1:0]             tx_count
);

  localparam int              SC_W       = clog2(STALL_TIMEOUT);
  localparam logic [SC_W-1:0] STALL_LAST = SC_W'(STALL_TIMEOUT - 1);

  arb_state_e            state_q, state_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [ID_W-1:0]       last_grant_q, last_grant_d;
  logic [ID_W-1:0]       stall_id_q, stall_id_d;
  logic [SC_W-1:0]       stall_q, stall_d;
  logic [CNT_W-1:0]      tx_count_q, tx_count_d;
  logic                  pkt_done_q, pkt_done_d;
  logic                  stall_err_q, stall_err_d;

  logic [NUM_REQ-1:0]    pick;
  logic                  any_valid;
  logic [ID_W-1:0]       owner_idx;
  logic                  own_valid;
  logic                  own_last;
  logic [DATA_SIZE-1:0]  own_data;
  logic                  in_xfer;
  logic                  accept;

  rr_pick #(
    .N(NUM_REQ)
  ) u_pick (
    .req_i       (req_valid),
    .last_grant_i(last_grant_q),
    .pick_o      (pick),
    .any_o       (any_valid)
  );

  // Route the owner's request lane out of the one-hot grant
  always_comb begin
    owner_idx = '0;
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        owner_idx = ID_W'(i);
        own_valid = req_valid[i];
        own_last  = req_last[i];
        own_data  = req_data[i*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

  assign in_xfer     = (state_q == ST_XFER);
  assign accept      = in_xfer & own_valid & ~wait_request_write;
  assign trans       = accept;
  assign bus_data_in = accept ? own_data : '0;
  assign req_ready   = (in_xfer && !wait_request_write) ? grant_q : '0;
  assign grant       = grant_q;
  assign busy        = in_xfer;
  assign pkt_done    = pkt_done_q;
  assign stall_err   = stall_err_q;
  assign stall_id    = stall_id_q;
  assign tx_count    = tx_count_q;

  // Next-state: arbitration in IDLE, byte transfer and watchdog in XFER
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    stall_id_d   = stall_id_q;
    stall_d      = stall_q;
    tx_count_d   = tx_count_q;
    pkt_done_d   = 1'b0;
    stall_err_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          grant_d = pick;
          stall_d = '0;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (accept) begin
          if (tx_count_q != {CNT_W{1'b1}}) tx_count_d = tx_count_q + 1'b1;
          stall_d = '0;
          if (own_last) begin
            pkt_done_d   = 1'b1;
            last_grant_d = owner_idx;
            grant_d      = '0;
            state_d      = ST_IDLE;
          end
        end else if (!own_valid) begin
          // Owner went quiet mid-packet; backpressure alone never counts
          if (stall_q == STALL_LAST) begin
            stall_err_d  = 1'b1;
            stall_id_d   = owner_idx;
            last_grant_d = owner_idx;
            grant_d      = '0;
            stall_d      = '0;
            state_d      = ST_IDLE;
          end else begin
            stall_d = stall_q + 1'b1;
          end
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; reset aborts any packet in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      stall_id_q   <= '0;
      stall_q      <= '0;
      tx_count_q   <= '0;
      pkt_done_q   <= 1'b0;
      stall_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      stall_id_q   <= stall_id_d;
      stall_q      <= stall_d;
      tx_count_q   <= tx_count_d;
      pkt_done_q   <= pkt_done_d;
      stall_err_q  <= stall_err_d;
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares the single UART transmit path (trans / bus_data_in / wait_request_write of uart_top) between NUM_REQ byte-stream requesters. Each requester gets packet-locked access: its grant holds until its last byte is accepted, so frames from different sources never interleave on the line. A stall watchdog reclaims the grant from a requester that stops supplying data mid-packet. The block sits between the bus-side sources (CPU port, ECC status reporter, debug) and uart_top.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_SIZE, 8, byte width, matches uart_top
STALL_TIMEOUT, 1024, cycles with granted req_valid low before the grant is revoked (>=2)
CNT_W, 16, width of the transmitted-byte counter

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester byte valid
req_data  input  NUM_REQ*DATA_SIZE  per-requester byte; requester i occupies bits [i*DATA_SIZE +: DATA_SIZE]
req_last  input  NUM_REQ  marks the final byte of a packet
req_ready  output  NUM_REQ  per-requester byte accepted this cycle when high together with valid
wait_request_write  input  1  from uart_top; high means the TX FIFO cannot take a byte
trans  output  1  write strobe to uart_top; one byte per high cycle
bus_data_in  output  DATA_SIZE  byte to uart_top, valid while trans is high
grant  output  NUM_REQ  one-hot current owner; all zero when idle
busy  output  1  high while in XFER
pkt_done  output  1  one-cycle pulse when a last byte is accepted
stall_err  output  1  one-cycle pulse when the watchdog revokes a grant
stall_id  output  $clog2(NUM_REQ)  index of the revoked requester; held until the next stall_err
tx_count  output  CNT_W  total bytes written to uart_top; saturates at all-ones

Behaviour:
- Reset (async, reset_n=0): state=IDLE, grant=0, last_grant=NUM_REQ-1 (req0 has first priority), stall counter=0, tx_count=0, stall_id=0, pkt_done=0, stall_err=0. trans, req_ready and busy are therefore 0.
- Reset asserted mid-packet aborts the packet immediately. No byte is written after reset asserts.
- Two states: IDLE and XFER.
- IDLE: if any req_valid is high, select the first valid index scanning last_grant+1, last_grant+2, ... modulo NUM_REQ. Register grant as one-hot, go to XFER. Selection is combinational, grant is registered, so there is one cycle from request to grant.
- XFER, with owner g:
  - req_ready[g] = !wait_request_write. Every other req_ready bit is 0.
  - trans = req_valid[g] & !wait_request_write (combinational, zero latency).
  - bus_data_in = req_data slice g when trans is high, else 0.
  - Accept = trans. On accept: tx_count += 1 unless saturated; stall counter clears.
  - Accept with req_last[g]: pkt_done pulses next cycle, last_grant <= g, grant <= 0, go to IDLE. The next arbitration starts in the following cycle, so there is a minimum one-cycle bubble between packets.
  - req_valid[g]=0: stall counter += 1.
  - req_valid[g]=1 with wait_request_write=1 is backpressure, not a stall; the counter holds.
  - Stall counter reaches STALL_TIMEOUT: stall_err pulses, stall_id <= g, last_grant <= g, grant <= 0, go to IDLE. The partial packet is not completed.
- Simultaneous events:
  - last and timeout in the same cycle: the accept wins; no stall_err.
  - Requests arriving during XFER wait; fairness is enforced only at grant time.
- Non-owner requesters must hold valid/data/last stable until ready. The arbiter never drops a byte that was not acknowledged.
- req_last on a non-granted requester has no effect.
- A single-byte packet (valid and last in the first XFER cycle) occupies one XFER cycle.

Decomposition:
- Shared package uart_pkg holds:
  - the DATA_SIZE default,
  - state encoding constants ST_IDLE and ST_XFER,
  - a clog2 function.
- One sub-module, rr_pick: purely combinational round-robin selector. Inputs: request vector and last_grant. Outputs: one-hot pick and an any-valid flag. Reused later by an RX-side dispatcher.
- Watchdog counter, tx_count and the FSM stay in uart_tx_arbiter.

Test Plan:
- Single requester: req1 sends 3 bytes 0x55, 0xAB, 0xCD (last on 0xCD), wait_request_write=0 -> grant=0010 one cycle after valid; trans high 3 consecutive cycles with bus_data_in 55, AB, CD; pkt_done pulse; tx_count=3.
- All four requesters with 2-byte packets valid at the same cycle after reset -> service order 0,1,2,3; each packet contiguous on the line; one idle cycle between packets; tx_count=8.
- Backpressure: wait_request_write held high for 10 cycles mid-packet from req2 -> trans=0 and req_ready=0 throughout; no stall_err; next byte sent in the first cycle after release; byte order preserved.
- Stall: STALL_TIMEOUT=8; req3 sends 1 byte then drops valid -> stall_err pulses after 8 cycles with stall_id=3; grant returns to 0; next arbitration starts from req0.
- Reset mid-packet: assert reset_n=0 asynchronously during byte 2 of 4 -> trans, grant and tx_count all 0 immediately; after release, req0 wins over req3 when both are valid.
- Saturation: preload traffic with CNT_W=4, send 20 bytes -> tx_count sticks at 15.
